adc_conv_sequencer: RTL and testbench

ADC_CONV_SEQUENCER -- requirements
Module: adc_conv_sequencer

---
 rtl/adc_seq_pkg.sv | 16 +
 rtl/adc_seq_sync2.sv | 25 ++
 rtl/adc_conv_sequencer.sv | 159 +++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
// Holds the FSM state encoding, the START phase length and the watchdog limit.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_START,
        ST_CONVERT,
        ST_DONE
    } adc_seq_state_e;

    localparam logic [1:0]  START_LEN  = 2'd2;
    localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/adc_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk.
// Latency 2 cycles; no backpressure.
module adc_seq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// SAR ADC conversion sequencer: sample phase, 2-cycle start pulse, wait for done, hold result until accepted.
// Optional CONVERT watchdog and timeout_out port are built only with ADC_SEQ_TIMEOUT_EN defined.
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int RESULT_W = 12,
    parameter int SMPL_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                conv_req_in,
    input  logic                continuous_in,
    input  logic [SMPL_W-1:0]   sample_len_in,
    input  logic                conv_done_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic                ena_out,
    output logic                start_conv_out,
    output logic                sample_p_out,
    output logic                sample_n_out,
    output logic                nsample_p_out,
    output logic                nsample_n_out,
    output logic [RESULT_W-1:0] result_out,
    output logic                result_valid_out,
    input  logic                result_ready_in,
    output logic                busy_out
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    output logic                timeout_out
`endif
);

    localparam logic [SMPL_W-1:0] CNT_ONE = SMPL_W'(1);

    adc_seq_state_e      state_q, state_d;
    logic [SMPL_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          start_cnt_q, start_cnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                done_sync;
    logic                done_prev_q;
    logic                done_rise;
    logic [SMPL_W-1:0]   smpl_load;
`ifdef ADC_SEQ_TIMEOUT_EN
    logic [15:0]         wdog_q, wdog_d;
    logic                timeout_q, timeout_d;
`endif

    adc_seq_sync2 u_done_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (conv_done_in),
        .q_out (done_sync)
    );

    // A zero-length sample request still gets one sampling cycle.
    assign smpl_load = (sample_len_in == '0) ? CNT_ONE : sample_len_in;
    assign done_rise = done_sync & ~done_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_cnt_q <= '0;
            result_q    <= '0;
            done_prev_q <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_cnt_q <= start_cnt_d;
            result_q    <= result_d;
            done_prev_q <= done_sync;
`ifdef ADC_SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_cnt_d = start_cnt_q;
        result_d    = result_q;
`ifdef ADC_SEQ_TIMEOUT_EN
        wdog_d      = '0;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (conv_req_in) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = smpl_load;
                end
            end
            ST_SAMPLE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d     = ST_START;
                    start_cnt_d = START_LEN;
                end
            end
            ST_START: begin
                start_cnt_d = start_cnt_q - 2'd1;
                if (start_cnt_q <= 2'd1) begin
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (done_rise) begin
                    state_d  = ST_DONE;
                    result_d = result_in;
`ifdef ADC_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
                end else if (wdog_q == WDOG_LIMIT - 16'd1) begin
                    state_d   = ST_DONE;
                    result_d  = '1;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
`endif
                end
            end
            ST_DONE: begin
                if (result_ready_in) begin
`ifdef ADC_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    if (continuous_in) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = smpl_load;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so an async reset drops them at once.
    assign sample_p_out     = (state_q == ST_SAMPLE);
    assign sample_n_out     = (state_q == ST_SAMPLE);
    assign nsample_p_out    = (state_q != ST_SAMPLE);
    assign nsample_n_out    = (state_q != ST_SAMPLE);
    assign start_conv_out   = (state_q == ST_START);
    assign ena_out          = (state_q == ST_START) || (state_q == ST_CONVERT);
    assign result_valid_out = (state_q == ST_DONE);
    assign busy_out         = (state_q != ST_IDLE);
    assign result_out       = result_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    assign timeout_out      = timeout_q;
`endif

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer with randomized conversions and timing-based expectations.
module tb_adc_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        conv_req = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  sample_len = 8'd0;
    logic        conv_done = 1'b0;
    logic [11:0] result_in = 12'd0;
    logic        result_ready = 1'b0;
    logic        ena_out, start_conv_out, sample_p_out, sample_n_out;
    logic        nsample_p_out, nsample_n_out, result_valid_out, busy_out;
    logic [11:0] result_out;
`ifdef ADC_SEQ_TIMEOUT_EN
    logic        timeout_out;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    adc_conv_sequencer #(.RESULT_W(12), .SMPL_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .conv_req_in      (conv_req),
        .continuous_in    (continuous),
        .sample_len_in    (sample_len),
        .conv_done_in     (conv_done),
        .result_in        (result_in),
        .ena_out          (ena_out),
        .start_conv_out   (start_conv_out),
        .sample_p_out     (sample_p_out),
        .sample_n_out     (sample_n_out),
        .nsample_p_out    (nsample_p_out),
        .nsample_n_out    (nsample_n_out),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .result_ready_in  (result_ready),
        .busy_out         (busy_out)
`ifdef ADC_SEQ_TIMEOUT_EN
        ,
        .timeout_out      (timeout_out)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    // Stimulus only: issues a request, raises done at cycle kd, and records the observed timeline.
    // Cycle k counts observation points after the edge that samples conv_req.
    task automatic measure_conv(input int len, input int dstart, input logic [11:0] val,
                                input int glitch_k, output int n_smpl, output int n_start,
                                output int first_start, output int valid_k, output int n_ena,
                                output int n_bad);
        int kd;
        kd = eff_len(len) + 1 + dstart;
        n_smpl = 0; n_start = 0; first_start = -1; valid_k = -1; n_ena = 0; n_bad = 0;
        sample_len = 8'(len);
        result_in = val;
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        for (int k = 1; k <= kd + 20 && valid_k < 0; k++) begin
            if (sample_p_out) n_smpl++;
            if (start_conv_out) begin
                n_start++;
                if (first_start < 0) first_start = k;
            end
            if (ena_out) n_ena++;
            if (sample_n_out !== sample_p_out || nsample_p_out !== ~sample_p_out ||
                nsample_n_out !== ~sample_p_out || busy_out !== 1'b1) n_bad++;
            if (result_valid_out) valid_k = k;
            else begin
                if (k == glitch_k) conv_done = 1'b1;
                if (k == glitch_k + 2) conv_done = 1'b0;
                if (k == kd) conv_done = 1'b1;
                step();
            end
        end
    endtask

    task automatic accept();
        conv_done = 1'b0;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({ena_out, start_conv_out, sample_p_out, sample_n_out, result_valid_out, busy_out} !== 6'b0)
            $display("FAIL reset_outs: got %b want 000000",
                     {ena_out, start_conv_out, sample_p_out, sample_n_out, result_valid_out, busy_out});
        else pass_cnt++;
        total_cnt++;
        if ({nsample_p_out, nsample_n_out} !== 2'b11)
            $display("FAIL reset_nsample: got %b want 11", {nsample_p_out, nsample_n_out});
        else pass_cnt++;
        total_cnt++;
        if (result_out !== 12'h000) $display("FAIL reset_result: got %h want 000", result_out);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_conversion();
        int lens[8];
        int dsts[8];
        logic [11:0] vals[8];
        int ns, nst, fs, vk, ne, nb, el, kd;
        lens[0] = 4; dsts[0] = 20; vals[0] = 12'hA5C;
        lens[1] = 0; dsts[1] = 3;  vals[1] = 12'h3C1;
        for (int i = 2; i < 8; i++) begin
            lens[i] = $urandom_range(0, 12);
            dsts[i] = $urandom_range(1, 30);
            vals[i] = 12'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            measure_conv(lens[i], dsts[i], vals[i], -1, ns, nst, fs, vk, ne, nb);
            el = eff_len(lens[i]);
            kd = el + 1 + dsts[i];
            total_cnt++;
            if (ns !== el) $display("FAIL conv%0d_sample_cycles: got %0d want %0d", i, ns, el);
            else pass_cnt++;
            total_cnt++;
            if (nst !== 2) $display("FAIL conv%0d_start_cycles: got %0d want 2", i, nst);
            else pass_cnt++;
            total_cnt++;
            if (fs !== el + 1) $display("FAIL conv%0d_start_latency: got %0d want %0d", i, fs, el + 1);
            else pass_cnt++;
            total_cnt++;
            if (vk !== kd + 3) $display("FAIL conv%0d_valid_latency: got %0d want %0d", i, vk, kd + 3);
            else pass_cnt++;
            total_cnt++;
            if (ne !== kd + 2 - el) $display("FAIL conv%0d_ena_cycles: got %0d want %0d", i, ne, kd + 2 - el);
            else pass_cnt++;
            total_cnt++;
            if (nb !== 0) $display("FAIL conv%0d_switch_busy: got %0d bad cycles want 0", i, nb);
            else pass_cnt++;
            total_cnt++;
            if (result_out !== vals[i]) $display("FAIL conv%0d_result: got %h want %h", i, result_out, vals[i]);
            else pass_cnt++;
            accept();
            total_cnt++;
            if ({busy_out, result_valid_out} !== 2'b00)
                $display("FAIL conv%0d_idle_after_accept: got %b want 00", i, {busy_out, result_valid_out});
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] v1, v2;
        int ns, nst, fs, vk, ne, nb, held_bad;
        v1 = 12'($urandom);
        v2 = ~v1;
        continuous = 1'b1;
        measure_conv(3, 6, v1, -1, ns, nst, fs, vk, ne, nb);
        total_cnt++;
        if (vk !== 13) $display("FAIL cont_first_valid: got %0d want 13", vk);
        else pass_cnt++;
        result_in = v2;
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!result_valid_out || result_out !== v1) held_bad++;
        end
        total_cnt++;
        if (held_bad !== 0) $display("FAIL cont_hold: got %0d bad cycles want 0", held_bad);
        else pass_cnt++;
        accept();
        continuous = 1'b0;
        total_cnt++;
        if (sample_p_out !== 1'b1) $display("FAIL cont_restart: got %b want 1", sample_p_out);
        else pass_cnt++;
        ns = 0; vk = -1;
        for (int k = 1; k <= 40 && vk < 0; k++) begin
            if (sample_p_out) ns++;
            if (result_valid_out) vk = k;
            else begin
                if (k == 10) conv_done = 1'b1;
                step();
            end
        end
        total_cnt++;
        if (ns !== 3) $display("FAIL cont_second_sample: got %0d want 3", ns);
        else pass_cnt++;
        total_cnt++;
        if (vk !== 13) $display("FAIL cont_second_valid: got %0d want 13", vk);
        else pass_cnt++;
        total_cnt++;
        if (result_out !== v2) $display("FAIL cont_second_result: got %h want %h", result_out, v2);
        else pass_cnt++;
        accept();
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL cont_stop_idle: got %b want 0", busy_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_convert();
        int bad;
        sample_len = 8'd2;
        result_in = 12'h777;
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        repeat (6) step();
        total_cnt++;
        if ({ena_out, start_conv_out} !== 2'b10)
            $display("FAIL rst_mid_in_convert: got %b want 10", {ena_out, start_conv_out});
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ena_out, nsample_p_out, nsample_n_out, busy_out} !== 4'b0110)
            $display("FAIL rst_mid_immediate: got %b want 0110",
                     {ena_out, nsample_p_out, nsample_n_out, busy_out});
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        conv_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (result_valid_out || busy_out) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL rst_mid_done_ignored: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        conv_done = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int ns, nst, fs, vk, ne, nb, bad;
        logic [11:0] v;
        bad = 0;
        conv_done = 1'b1;
        step();
        step();
        conv_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy_out || result_valid_out) bad++;
            step();
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL glitch_idle: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        v = 12'($urandom);
        measure_conv(8, 5, v, 1, ns, nst, fs, vk, ne, nb);
        total_cnt++;
        if (ns !== 8) $display("FAIL glitch_sample_cycles: got %0d want 8", ns);
        else pass_cnt++;
        total_cnt++;
        if (fs !== 9) $display("FAIL glitch_start_latency: got %0d want 9", fs);
        else pass_cnt++;
        total_cnt++;
        if (vk !== 17) $display("FAIL glitch_valid_latency: got %0d want 17", vk);
        else pass_cnt++;
        total_cnt++;
        if (result_out !== v) $display("FAIL glitch_result: got %h want %h", result_out, v);
        else pass_cnt++;
        accept();
    endtask

`ifdef ADC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n_conv, vk;
        sample_len = 8'd1;
        result_in = 12'h123;
        conv_req = 1'b1;
        step();
        conv_req = 1'b0;
        n_conv = 0; vk = -1;
        for (int k = 1; k <= 70000 && vk < 0; k++) begin
            if (ena_out && !start_conv_out) n_conv++;
            if (result_valid_out) vk = k;
            else step();
        end
        total_cnt++;
        if (n_conv !== 65535) $display("FAIL timeout_cycles: got %0d want 65535", n_conv);
        else pass_cnt++;
        total_cnt++;
        if (result_out !== 12'hFFF || timeout_out !== 1'b1)
            $display("FAIL timeout_result: got %h/%b want fff/1", result_out, timeout_out);
        else pass_cnt++;
        accept();
    endtask
`endif

    initial begin
        test_reset();
        test_conversion();
        test_back_to_back();
        test_reset_mid_convert();
        test_glitch();
`ifdef ADC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
